// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source interrupt controller with a four-word register window
// (ACK, MASK, PEND, EDGE). Sources are edge- or level-sensitive per bit, and
// the raw pending bits are latched into the PEND register.
//
// An IDLE/ACTIVE/HOLD state machine captures a service vector and presents it
// on hwint until software writes ACK. After the ACK, hwint is held low for
// QUIET_CYC cycles.
//
// Optional feature, macro IRQ_PRIO_EN: when defined, the service vector keeps
// only the lowest-index pending-and-enabled bit. When it is undefined, all such
// bits are serviced together.
module irq_ctrl #(
  parameter int unsigned QUIET_CYC = 3,
  parameter logic [31:0] BASE      = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  src,
  input  logic [31:0] pr_a,
  input  logic        pr_we,
  input  logic [31:0] pr_wd,
  output logic [31:0] pr_rd,
  output logic [5:0]  hwint
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  localparam logic [3:0] QUIET = 4'(QUIET_CYC);

  state_t      state_reg;
  logic [5:0]  mask_reg;
  logic [5:0]  edge_reg;
  logic [5:0]  pend_reg;
  logic [5:0]  pend_next;
  logic [5:0]  prev_reg;
  logic [5:0]  svc_reg;
  logic [3:0]  cnt_reg;
  logic [5:0]  hwint_reg;
  logic [5:0]  svc_cap;

  // Address decode: the window is four words, and only word-aligned accesses hit it.
  logic       in_win;
  logic [1:0] off;
  logic       wr_ack;
  logic       wr_mask;
  logic       wr_pend;
  logic       wr_edge;
  logic       ack_fire;
  logic       unused_wd;

  assign in_win   = (pr_a[31:4] == BASE[31:4]) && (pr_a[1:0] == 2'b00);
  assign off      = pr_a[3:2];
  assign wr_ack   = pr_we && in_win && (off == 2'd0);
  assign wr_mask  = pr_we && in_win && (off == 2'd1);
  assign wr_pend  = pr_we && in_win && (off == 2'd2);
  assign wr_edge  = pr_we && in_win && (off == 2'd3);
  // ACK only has an effect while a service is in progress.
  assign ack_fire = wr_ack && (state_reg == ACTIVE);
  assign unused_wd = ^pr_wd[31:6];

  // Per-bit pending logic. An edge bit is sticky until it is cleared by W1C or
  // ACK, and a new rising edge in the same cycle wins over the clear. A level
  // bit simply mirrors the source one cycle late.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_pend
      logic rise;
      logic clr;
      assign rise = src[gi] & ~prev_reg[gi];
      assign clr  = (wr_pend & pr_wd[gi]) | (ack_fire & svc_reg[gi]);
      assign pend_next[gi] = edge_reg[gi] ? (rise | (pend_reg[gi] & ~clr))
                                          : src[gi];
    end
  endgenerate

  // Service vector captured on IDLE->ACTIVE.
`ifdef IRQ_PRIO_EN
  logic [5:0] req;
  assign req     = pend_reg & mask_reg;
  assign svc_cap = req & (~req + 6'd1);
`else
  assign svc_cap = pend_reg & mask_reg;
`endif

  // Software-visible registers and the source previous-sample register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg <= '0;
      edge_reg <= '0;
      pend_reg <= '0;
      prev_reg <= '0;
    end else begin
      prev_reg <= src;
      pend_reg <= pend_next;
      if (wr_mask) mask_reg <= pr_wd[5:0];
      if (wr_edge) edge_reg <= pr_wd[5:0];
    end
  end

  // Service FSM: capture, hold until ACK, then quiet period before re-arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      svc_reg   <= '0;
      cnt_reg   <= '0;
      hwint_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          hwint_reg <= '0;
          if ((pend_reg & mask_reg) != 6'd0) begin
            svc_reg   <= svc_cap;
            hwint_reg <= svc_cap;
            state_reg <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (wr_ack) begin
            hwint_reg <= '0;
            cnt_reg   <= QUIET;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          hwint_reg <= '0;
          if (cnt_reg <= 4'd1) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          hwint_reg <= '0;
        end
      endcase
    end
  end

  assign hwint = hwint_reg;

  // Combinational read mux; out-of-window and ACK reads return zero.
  always_comb begin
    pr_rd = 32'd0;
    if (in_win) begin
      case (off)
        2'd1:    pr_rd = {26'd0, mask_reg};
        2'd2:    pr_rd = {26'd0, pend_reg};
        2'd3:    pr_rd = {26'd0, edge_reg};
        default: pr_rd = 32'd0;
      endcase
    end
  end

endmodule
